// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared state encoding and counter limits for pwm_capture
package pwm_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_HIGH,
        ST_LOW,
        ST_STUCK
    } state_e;

    function automatic logic [31:0] cnt_max(input int unsigned bits);
        cnt_max = (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// rtl/pwm_capture_sync_edge.sv - N-stage input synchronizer with rise/fall detect
module pwm_capture_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o,
    output logic ready_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] fill_q;
    logic              s_d_q;

    // fill_q marks when sync_o carries a real input sample rather than a reset zero
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            fill_q <= {fill_q[STAGES-2:0], 1'b1};
            s_d_q  <= sync_q[STAGES-1];
        end
    end

    assign sync_o  = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~s_d_q;
    assign fall_o  = ~sync_q[STAGES-1] & s_d_q;
    assign ready_o = fill_q[STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high time and period of an incoming PWM signal
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int CNT_BITS    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_in,
    output logic [CNT_BITS-1:0] high_cnt,
    output logic [CNT_BITS-1:0] period_cnt,
    output logic [BITS-1:0]     level,
    output logic                match,
    output logic                stuck,
    output logic                valid
);

    localparam logic [CNT_BITS-1:0] MAX    = CNT_BITS'(cnt_max(CNT_BITS));
    localparam logic [CNT_BITS-1:0] ONE    = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] FULL_P = ONE << BITS;

    logic s, rise, fall, ready;

    pwm_capture_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (pwm_in),
        .sync_o  (s),
        .rise_o  (rise),
        .fall_o  (fall),
        .ready_o (ready)
    );

    state_e              state_q;
    logic [CNT_BITS-1:0] cnt_p_q, cnt_h_q, idle_q;
    logic [CNT_BITS-1:0] cnt_p_d, cnt_h_d, idle_d;
    logic [CNT_BITS-1:0] high_q, period_q;
    logic [BITS-1:0]     level_q;
    logic                match_q, stuck_q, valid_q;
    logic                timeout;

    always_comb begin
        cnt_p_d = (cnt_p_q == MAX) ? MAX : cnt_p_q + 1'b1;
        cnt_h_d = (cnt_h_q == MAX) ? MAX : cnt_h_q + 1'b1;
        idle_d  = (idle_q == MAX) ? MAX : idle_q + 1'b1;
        // any edge restarts the idle counter, so it also wins over a coincident timeout
        timeout = (state_q != ST_STUCK) && !rise && !fall
                  && (idle_d == MAX) && (idle_q != MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_p_q  <= '0;
            cnt_h_q  <= '0;
            idle_q   <= '0;
            high_q   <= '0;
            period_q <= '0;
            level_q  <= '0;
            match_q  <= 1'b0;
            stuck_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            idle_q  <= (rise || fall) ? '0 : idle_d;
            if (timeout) begin
                valid_q  <= 1'b1;
                stuck_q  <= 1'b1;
                period_q <= MAX;
                high_q   <= s ? MAX : '0;
                level_q  <= s ? '1 : '0;
                match_q  <= !s;
                state_q  <= ST_STUCK;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (ready && !s) state_q <= ST_ARM;
                    end
                    ST_ARM, ST_STUCK: begin
                        if (rise) begin
                            cnt_p_q <= ONE;
                            cnt_h_q <= ONE;
                            state_q <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        cnt_p_q <= cnt_p_d;
                        if (fall) state_q <= ST_LOW;
                        else      cnt_h_q <= cnt_h_d;
                    end
                    ST_LOW: begin
                        if (rise) begin
                            valid_q  <= 1'b1;
                            stuck_q  <= 1'b0;
                            high_q   <= cnt_h_q;
                            period_q <= cnt_p_q;
                            match_q  <= (cnt_p_q == FULL_P);
                            level_q  <= (cnt_p_q == FULL_P) ? cnt_h_q[BITS-1:0] : '0;
                            cnt_p_q  <= ONE;
                            cnt_h_q  <= ONE;
                            state_q  <= ST_HIGH;
                        end else begin
                            cnt_p_q <= cnt_p_d;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign high_cnt   = high_q;
    assign period_cnt = period_q;
    assign level      = level_q;
    assign match      = match_q;
    assign stuck      = stuck_q;
    assign valid      = valid_q;

endmodule
